// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized rxd, mid-bit sampling, AXI-Stream-style byte output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_WIDTH  = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_tdata,
  output logic                  rx_tvalid,
  input  logic                  rx_tready,
`ifdef UART_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int BCW          = $clog2(CLKS_PER_BIT) + 1;
  localparam int ICW          = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DELIVER,
    S_WAIT_IDLE
  } state_t;

  state_t                state;
  logic                  rxd_m;
  logic                  rxd_s;
  logic [BCW-1:0]        baud_cnt;
  logic [ICW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  bit_end;
`ifdef UART_RX_PARITY_EN
  logic                  par_bad;
`endif

  assign bit_end = (baud_cnt == BCW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_tdata  <= '0;
      rx_tvalid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rxd_m     <= rxd;
      rxd_s     <= rxd_m;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_tvalid && rx_tready)
        rx_tvalid <= 1'b0;

      unique case (state)
        // Detection cycle counts as the first cycle of the half bit.
        S_IDLE: begin
          if (!rxd_s) begin
            baud_cnt <= BCW'(1);
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_cnt == BCW'(HALF_BIT - 1)) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {rxd_s, shreg[DATA_WIDTH-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == ICW'(DATA_WIDTH - 1))
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            par_bad  <= ((^shreg) ^ rxd_s) != PARITY_ODD;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            frame_err <= !rxd_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= par_bad;
            if (!rxd_s)
              state <= S_WAIT_IDLE;
            else if (par_bad)
              state <= S_IDLE;
            else
              state <= S_DELIVER;
`else
            state <= rxd_s ? S_DELIVER : S_WAIT_IDLE;
`endif
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (!rx_tvalid || rx_tready) begin
            rx_tdata  <= shreg;
            rx_tvalid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          state <= S_IDLE;
        end
        S_WAIT_IDLE: begin
          if (rxd_s)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive half of the FTDI UART link: deserializes the asynchronous `rxd` line into bytes and presents them on an AXI-Stream-style source (tdata/tvalid/tready).
- Sits between the board pin `ftdi_uart_rx` and any consumer of the rx stream, in the `clk_100` domain.
- 8N1 framing by default; flags framing errors and overruns.

Parameters:
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- BAUD_RATE, 115200, line bit rate.
- DATA_WIDTH, 8, data bits per frame, LSB first.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (integer floor, 868 at defaults), derived localparam; not to be overridden.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial input; idles high.
- rx_tdata  output  DATA_WIDTH  received byte.
- rx_tvalid  output  1  rx_tdata holds an unconsumed byte.
- rx_tready  input  1  consumer accepts the byte when rx_tvalid && rx_tready at a rising clk edge.
- frame_err  output  1  one-cycle pulse: the stop bit sampled low.
- overrun  output  1  sticky; set when a completed byte is dropped; cleared only by reset.

Behaviour:
- Reset:
  - Applied on the clk edge while reset=1 (synchronous, active-high).
  - Outputs: rx_tdata=0, rx_tvalid=0, frame_err=0, overrun=0.
  - Internal state: FSM=IDLE, bit counter=0, baud counter=0, synchronizer flops=1.
  - Reset mid-frame abandons the frame; no byte is emitted.
- Input synchronization: rxd passes through a 2-flop synchronizer (init 1). All decisions use the synchronized value, which adds 2 cycles of latency.
- IDLE: wait for synchronized rxd=0, then load baud counter and go to START.
- START:
  - Count CLKS_PER_BIT/2 cycles (434 at defaults), then re-sample.
  - If low, go to DATA with baud counter=0 and bit index=0.
  - If high (glitch), return to IDLE with no output and no error.
- DATA:
  - Every CLKS_PER_BIT cycles, sample once (mid-bit) and shift in LSB first.
  - After DATA_WIDTH samples, go to PARITY if enabled, else STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample.
  - High: frame good, go to DELIVER.
  - Low: pulse frame_err for exactly 1 cycle, discard the byte, go to WAIT_IDLE.
- WAIT_IDLE (break handling): stay until synchronized rxd=1, then go to IDLE.
- DELIVER (1 cycle):
  - If rx_tvalid=0, or rx_tvalid=1 with rx_tready=1 in this same cycle: load rx_tdata and set rx_tvalid=1.
  - Otherwise the new byte is dropped, overrun←1, and the held rx_tdata is unchanged.
  - Return to IDLE. New start-bit detection is possible from the next cycle; the stop bit is treated as half-consumed.
- Output handshake:
  - rx_tvalid, once set, stays high and rx_tdata stays stable until a cycle with rx_tready=1.
  - rx_tvalid then clears on that edge, unless DELIVER loads a new byte on the same edge, in which case rx_tvalid stays 1 with the new data.
  - rx_tready has no combinational path to any output.
- Latency: from the rxd falling edge at the pin to rx_tvalid rising = 2 + CLKS_PER_BIT/2 + (DATA_WIDTH+1)·CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity).
- Counters: baud counter is $clog2(CLKS_PER_BIT)+1 bits wide and wraps to 0 after each sample; bit counter is $clog2(DATA_WIDTH)+1 bits wide.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Parameter PARITY_ODD (default 0 = even parity) is added.
  - A PARITY state samples one extra bit after the data bits.
  - Output port parity_err (1-bit) pulses for 1 cycle in STOP on mismatch.
  - A mismatched byte is discarded: not delivered, no overrun set.
  - A simultaneous framing error pulses both parity_err and frame_err.
- When undefined: no PARITY state, no parity_err port, frame is 8N1.

Test Plan:
- Reset then idle line 1 for 10000 cycles → rx_tvalid=0, frame_err=0, overrun=0 throughout.
- Send 0xA5 at 868 clk/bit with rx_tready held 1 → rx_tvalid high for exactly 1 cycle, rx_tdata=0xA5, at cycle 2+434+9·868+1 after the falling edge.
- rx_tready=0, send 0x3C then 0xC3 back-to-back → rx_tdata stays 0x3C, overrun=1 after the second frame; raising rx_tready consumes 0x3C, then rx_tvalid=0.
- Stop bit driven 0 on byte 0x55 → frame_err pulses 1 cycle, rx_tvalid stays 0; line held low 20000 cycles then released, and a following 0x11 is received correctly.
- 200-cycle low glitch on idle line → no output, no error; assert reset during bit 4 of a 0xFF frame → no byte emitted, and the next frame 0x81 is received correctly.
- With UART_RX_PARITY_EN, PARITY_ODD=0: 0x07 with parity bit 1 → delivered; 0x07 with parity bit 0 → parity_err pulse, no delivery.
